// File: rtl/twd_trans_splitter_if.sv
// Bundle between a 2D transaction splitter, its descriptor source, its row-parameter queue and its row sink.
// Signal suffixes are named from the splitter's point of view.
interface twd_trans_splitter_if #(
  parameter int ADDR_WIDTH          = 32,
  parameter int LEN_WIDTH           = 16,
  parameter int TWD_COUNT_WIDTH     = 16,
  parameter int TWD_STRIDE_WIDTH    = 16,
  parameter int TWD_QUEUE_ADD_WIDTH = 2,
  parameter int TWD_QUEUE_WIDTH     = TWD_COUNT_WIDTH + TWD_STRIDE_WIDTH
);
  logic                           in_req_i;
  logic                           in_gnt_o;
  logic [ADDR_WIDTH-1:0]          in_add_i;
  logic [LEN_WIDTH-1:0]           in_len_i;
  logic                           in_twd_i;
  logic [TWD_QUEUE_ADD_WIDTH-1:0] in_twd_add_i;
  logic                           twd_rd_req_o;
  logic [TWD_QUEUE_ADD_WIDTH-1:0] twd_rd_add_o;
  logic [TWD_QUEUE_WIDTH-1:0]     twd_rd_dat_i;
  logic                           out_req_o;
  logic                           out_gnt_i;
  logic [ADDR_WIDTH-1:0]          out_add_o;
  logic [LEN_WIDTH-1:0]           out_len_o;
  logic                           out_last_o;
  logic                           busy_o;

  modport slave (
    input  in_req_i, in_add_i, in_len_i, in_twd_i, in_twd_add_i,
    input  twd_rd_dat_i, out_gnt_i,
    output in_gnt_o, twd_rd_req_o, twd_rd_add_o,
    output out_req_o, out_add_o, out_len_o, out_last_o, busy_o
  );

  modport master (
    output in_req_i, in_add_i, in_len_i, in_twd_i, in_twd_add_i,
    output twd_rd_dat_i, out_gnt_i,
    input  in_gnt_o, twd_rd_req_o, twd_rd_add_o,
    input  out_req_o, out_add_o, out_len_o, out_last_o, busy_o
  );
endinterface

// File: rtl/twd_trans_splitter.sv
// Splits a (possibly 2D) transaction descriptor into a sequence of 1D row transactions,
// fetching count/stride from the 2D queue slot (which frees it) for 2D transactions.
module twd_trans_splitter #(
  parameter int ADDR_WIDTH          = 32,
  parameter int LEN_WIDTH           = 16,
  parameter int TWD_COUNT_WIDTH     = 16,
  parameter int TWD_STRIDE_WIDTH    = 16,
  parameter int TWD_QUEUE_ADD_WIDTH = 2,
  parameter int TWD_QUEUE_WIDTH     = TWD_COUNT_WIDTH + TWD_STRIDE_WIDTH
) (
  input  logic clk_i,
  input  logic rst_i,
  twd_trans_splitter_if.slave bus
);

  typedef enum logic [1:0] {ST_IDLE, ST_FETCH, ST_SPLIT} state_t;

  state_t                         r_state;
  state_t                         w_state_next;
  logic [ADDR_WIDTH-1:0]          r_cur_add;
  logic [ADDR_WIDTH-1:0]          r_stride;
  logic [LEN_WIDTH-1:0]           r_rem;
  logic [LEN_WIDTH-1:0]           r_row_len;
  logic [TWD_QUEUE_ADD_WIDTH-1:0] r_slot;
  logic                           r_drop;

  logic                           w_in_hs;
  logic                           w_row_gnt;
  logic [LEN_WIDTH-1:0]           w_out_len;
  logic                           w_out_last;
  logic [TWD_COUNT_WIDTH-1:0]     w_count;
  logic [TWD_STRIDE_WIDTH-1:0]    w_stride_q;

  assign w_count    = bus.twd_rd_dat_i[TWD_COUNT_WIDTH-1:0];
  assign w_stride_q = bus.twd_rd_dat_i[TWD_QUEUE_WIDTH-1:TWD_COUNT_WIDTH];
  assign w_in_hs    = bus.in_req_i && (r_state == ST_IDLE);
  assign w_row_gnt  = (r_state == ST_SPLIT) && bus.out_gnt_i;
  assign w_out_len  = (r_row_len < r_rem) ? r_row_len : r_rem;
  assign w_out_last = (r_rem <= r_row_len);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_in_hs) begin
          // A zero-length 2D descriptor still visits FETCH so its slot is released.
          if (bus.in_twd_i)           w_state_next = ST_FETCH;
          else if (bus.in_len_i != '0) w_state_next = ST_SPLIT;
        end
      end
      ST_FETCH: w_state_next = r_drop ? ST_IDLE : ST_SPLIT;
      ST_SPLIT: if (w_row_gnt && w_out_last) w_state_next = ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.in_gnt_o     = 1'b0;
    bus.twd_rd_req_o = 1'b0;
    bus.twd_rd_add_o = '0;
    bus.out_req_o    = 1'b0;
    bus.out_add_o    = '0;
    bus.out_len_o    = '0;
    bus.out_last_o   = 1'b0;
    bus.busy_o       = 1'b0;
    case (r_state)
      ST_IDLE:  bus.in_gnt_o = !rst_i;
      ST_FETCH: begin
        bus.twd_rd_req_o = 1'b1;
        bus.twd_rd_add_o = r_slot;
        bus.busy_o       = 1'b1;
      end
      ST_SPLIT: begin
        bus.out_req_o  = 1'b1;
        bus.out_add_o  = r_cur_add;
        bus.out_len_o  = w_out_len;
        bus.out_last_o = w_out_last;
        bus.busy_o     = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cur_add <= '0;
      r_stride  <= '0;
      r_rem     <= '0;
      r_row_len <= '0;
      r_slot    <= '0;
      r_drop    <= 1'b0;
    end else begin
      if (w_in_hs) begin
        r_cur_add <= bus.in_add_i;
        r_rem     <= bus.in_len_i;
        r_row_len <= bus.in_len_i;
        r_stride  <= '0;
        r_slot    <= bus.in_twd_add_i;
        r_drop    <= (bus.in_len_i == '0);
      end
      if (r_state == ST_FETCH) begin
        // count==0 means "one row covering everything" rather than an endless zero-length loop.
        r_row_len <= (w_count == '0) ? r_rem : LEN_WIDTH'(w_count);
        r_stride  <= ADDR_WIDTH'(w_stride_q);
      end
      if (w_row_gnt) begin
        r_cur_add <= r_cur_add + ADDR_WIDTH'(r_row_len) + r_stride;
        r_rem     <= r_rem - w_out_len;
      end
    end
  end

endmodule

// File: tb/tb_twd_trans_splitter.sv
// Directed bench for twd_trans_splitter: each descriptor is checked cycle by cycle
// against hand-computed rows.
module tb_twd_trans_splitter;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  logic [31:0] slot_mem [4];
  logic [31:0] exp_add  [8];
  logic [15:0] exp_len  [8];
  int          n_rows;

  twd_trans_splitter_if bus ();

  twd_trans_splitter dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  always #5 clk_i = ~clk_i;

  assign bus.twd_rd_dat_i = slot_mem[bus.twd_rd_add_o];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
    end
  endtask

  // Presents one descriptor; returns at the falling edge of cycle N+1.
  task automatic issue(input logic [31:0] a, input logic [15:0] l, input logic t, input logic [1:0] s);
    @(negedge clk_i);
    chk("in_gnt_idle", 64'(bus.in_gnt_o), 64'd1);
    bus.in_req_i     = 1'b1;
    bus.in_add_i     = a;
    bus.in_len_i     = l;
    bus.in_twd_i     = t;
    bus.in_twd_add_i = s;
    @(negedge clk_i);
    bus.in_req_i     = 1'b0;
    $display("trans add=0x%08h len=%0d twd=%0d slot=%0d", a, l, t, s);
  endtask

  task automatic expect_rows(input logic t, input logic [1:0] s);
    if (t) begin
      chk("rd_req", 64'(bus.twd_rd_req_o), 64'd1);
      chk("rd_add", 64'(bus.twd_rd_add_o), 64'(s));
      chk("out_req_fetch", 64'(bus.out_req_o), 64'd0);
      @(negedge clk_i);
    end
    for (int i = 0; i < n_rows; i++) begin
      chk("out_req", 64'(bus.out_req_o), 64'd1);
      chk("out_add", 64'(bus.out_add_o), 64'(exp_add[i]));
      chk("out_len", 64'(bus.out_len_o), 64'(exp_len[i]));
      chk("out_last", 64'(bus.out_last_o), 64'(i == n_rows - 1));
      chk("rd_req_split", 64'(bus.twd_rd_req_o), 64'd0);
      chk("in_gnt_busy", 64'(bus.in_gnt_o), 64'd0);
      @(negedge clk_i);
    end
    chk("out_req_done", 64'(bus.out_req_o), 64'd0);
    chk("in_gnt_done", 64'(bus.in_gnt_o), 64'd1);
    chk("busy_done", 64'(bus.busy_o), 64'd0);
  endtask

  initial begin
    bus.in_req_i     = 1'b0;
    bus.in_add_i     = '0;
    bus.in_len_i     = '0;
    bus.in_twd_i     = 1'b0;
    bus.in_twd_add_i = '0;
    bus.out_gnt_i    = 1'b1;
    for (int i = 0; i < 4; i++) slot_mem[i] = '0;
    slot_mem[1] = {16'h0040, 16'd64};
    slot_mem[2] = {16'h00C0, 16'd64};
    slot_mem[3] = {16'h01C0, 16'd64};

    #1;
    chk("rst_out_req", 64'(bus.out_req_o), 64'd0);
    chk("rst_rd_req", 64'(bus.twd_rd_req_o), 64'd0);
    chk("rst_in_gnt", 64'(bus.in_gnt_o), 64'd0);
    chk("rst_busy", 64'(bus.busy_o), 64'd0);
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;

    // 1D single row
    issue(32'h1000, 16'd64, 1'b0, 2'd0);
    n_rows = 1; exp_add[0] = 32'h1000; exp_len[0] = 16'd64;
    expect_rows(1'b0, 2'd0);

    // 2D, four full rows
    issue(32'h1000, 16'd256, 1'b1, 2'd2);
    n_rows = 4;
    exp_add[0] = 32'h1000; exp_add[1] = 32'h1100; exp_add[2] = 32'h1200; exp_add[3] = 32'h1300;
    for (int i = 0; i < 4; i++) exp_len[i] = 16'd64;
    expect_rows(1'b1, 2'd2);

    // 2D, partial last row
    issue(32'h0, 16'd150, 1'b1, 2'd1);
    n_rows = 3;
    exp_add[0] = 32'h0;   exp_len[0] = 16'd64;
    exp_add[1] = 32'h80;  exp_len[1] = 16'd64;
    exp_add[2] = 32'h100; exp_len[2] = 16'd22;
    expect_rows(1'b1, 2'd1);

    // Same transaction with backpressure on row 2
    issue(32'h0, 16'd150, 1'b1, 2'd1);
    chk("bp_rd_req", 64'(bus.twd_rd_req_o), 64'd1);
    @(negedge clk_i);
    chk("bp_row0_add", 64'(bus.out_add_o), 64'h0);
    @(negedge clk_i);
    bus.out_gnt_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("bp_hold_req", 64'(bus.out_req_o), 64'd1);
      chk("bp_hold_add", 64'(bus.out_add_o), 64'h80);
      chk("bp_hold_len", 64'(bus.out_len_o), 64'd64);
      chk("bp_hold_last", 64'(bus.out_last_o), 64'd0);
      @(negedge clk_i);
    end
    bus.out_gnt_i = 1'b1;
    chk("bp_resume_add", 64'(bus.out_add_o), 64'h80);
    @(negedge clk_i);
    chk("bp_row2_add", 64'(bus.out_add_o), 64'h100);
    chk("bp_row2_len", 64'(bus.out_len_o), 64'd22);
    chk("bp_row2_last", 64'(bus.out_last_o), 64'd1);
    @(negedge clk_i);
    chk("bp_done", 64'(bus.out_req_o), 64'd0);

    // count == 0 -> single row of the whole length
    issue(32'h2000, 16'd100, 1'b1, 2'd0);
    n_rows = 1; exp_add[0] = 32'h2000; exp_len[0] = 16'd100;
    expect_rows(1'b1, 2'd0);

    // 2D, len 0: one slot-freeing read, no rows
    issue(32'h3000, 16'd0, 1'b1, 2'd3);
    chk("z2d_rd_req", 64'(bus.twd_rd_req_o), 64'd1);
    chk("z2d_rd_add", 64'(bus.twd_rd_add_o), 64'd3);
    chk("z2d_out_req", 64'(bus.out_req_o), 64'd0);
    @(negedge clk_i);
    chk("z2d_rd_req_off", 64'(bus.twd_rd_req_o), 64'd0);
    chk("z2d_out_req_off", 64'(bus.out_req_o), 64'd0);
    chk("z2d_idle", 64'(bus.in_gnt_o), 64'd1);

    // 1D, len 0: nothing at all
    issue(32'h3000, 16'd0, 1'b0, 2'd3);
    chk("z1d_rd_req", 64'(bus.twd_rd_req_o), 64'd0);
    chk("z1d_out_req", 64'(bus.out_req_o), 64'd0);
    chk("z1d_busy", 64'(bus.busy_o), 64'd0);
    chk("z1d_in_gnt", 64'(bus.in_gnt_o), 64'd1);

    // Address wrap
    issue(32'hFFFFFF00, 16'd128, 1'b1, 2'd3);
    n_rows = 2;
    exp_add[0] = 32'hFFFFFF00; exp_len[0] = 16'd64;
    exp_add[1] = 32'h00000100; exp_len[1] = 16'd64;
    expect_rows(1'b1, 2'd3);

    // Reset during SPLIT
    issue(32'h1000, 16'd256, 1'b1, 2'd2);
    @(negedge clk_i);
    @(negedge clk_i);
    chk("rs_pre_add", 64'(bus.out_add_o), 64'h1100);
    rst_i = 1'b1;
    #1;
    chk("rs_out_req", 64'(bus.out_req_o), 64'd0);
    chk("rs_out_add", 64'(bus.out_add_o), 64'd0);
    chk("rs_out_len", 64'(bus.out_len_o), 64'd0);
    chk("rs_out_last", 64'(bus.out_last_o), 64'd0);
    chk("rs_rd_req", 64'(bus.twd_rd_req_o), 64'd0);
    chk("rs_busy", 64'(bus.busy_o), 64'd0);
    chk("rs_in_gnt", 64'(bus.in_gnt_o), 64'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    chk("rs_rel_in_gnt", 64'(bus.in_gnt_o), 64'd1);
    chk("rs_rel_busy", 64'(bus.busy_o), 64'd0);
    @(negedge clk_i);
    chk("rs_no_resume", 64'(bus.out_req_o), 64'd0);
    chk("rs_no_rd", 64'(bus.twd_rd_req_o), 64'd0);

    // Back-to-back after reset: a fresh 1D transaction behaves normally
    issue(32'h4000, 16'd32, 1'b0, 2'd0);
    n_rows = 1; exp_add[0] = 32'h4000; exp_len[0] = 16'd32;
    expect_rows(1'b0, 2'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/twd_trans_splitter.md
Name: twd_trans_splitter

Overview:
- Consumer side of the 2D transaction queue: the TX or RX unit instantiates one splitter per direction.
- Accepts a transaction descriptor (external address, total length, 2D flag, queue slot).
- For 2D transactions, reads the slot's row parameters from the queue, which frees the slot.
- Emits a sequence of 1D row transactions, advancing the external address by the stride each row.

Parameters:
- ADDR_WIDTH, 32, external address width.
- LEN_WIDTH, 16, total transfer length width (bytes).
- TWD_COUNT_WIDTH, 16, row length field width (bytes).
- TWD_STRIDE_WIDTH, 16, row stride field width (bytes).
- TWD_QUEUE_ADD_WIDTH, 2, queue slot index width.
- TWD_QUEUE_WIDTH, TWD_COUNT_WIDTH+TWD_STRIDE_WIDTH, queue entry width. Count is in the LSBs, stride in the MSBs.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous reset, active-high.
- in_req_i  in  1  transaction valid.
- in_gnt_o  out  1  transaction accepted.
- in_add_i  in  ADDR_WIDTH  start external address.
- in_len_i  in  LEN_WIDTH  total bytes.
- in_twd_i  in  1  1 = 2D transaction.
- in_twd_add_i  in  TWD_QUEUE_ADD_WIDTH  queue slot holding the row parameters.
- twd_rd_req_o  out  1  queue read; frees the slot.
- twd_rd_add_o  out  TWD_QUEUE_ADD_WIDTH  slot read.
- twd_rd_dat_i  in  TWD_QUEUE_WIDTH  slot contents; combinational, valid in the same cycle as the request.
- out_req_o  out  1  row transaction valid.
- out_gnt_i  in  1  row accepted.
- out_add_o  out  ADDR_WIDTH  row address.
- out_len_o  out  LEN_WIDTH  row bytes.
- out_last_o  out  1  final row of the transaction.
- busy_o  out  1  state != IDLE.

Behaviour:
- Reset: all outputs 0, state IDLE, internal registers 0. Asserting rst_i mid-transaction aborts the transaction; no further twd_rd_req_o is issued.
- FSM states: IDLE, FETCH, SPLIT.
- IDLE:
  - in_gnt_o=1 (combinational on state). Handshake when in_req_i && in_gnt_o.
  - On handshake, latch cur_add=in_add_i and rem=in_len_i.
  - in_len_i==0: transaction is dropped. Stay IDLE; no output and no queue read. If in_twd_i=1, the slot is still freed by a one-cycle twd_rd_req_o on the next cycle, via FETCH then back to IDLE.
  - in_twd_i=0, len>0: row_len=in_len_i, stride=0 → SPLIT.
  - in_twd_i=1: latch the slot → FETCH.
- FETCH (exactly 1 cycle):
  - twd_rd_req_o=1 and twd_rd_add_o=slot. Sample count/stride from twd_rd_dat_i in the same cycle.
  - count==0 is treated as row_len=rem, giving a single row with no infinite loop.
  - Next state is SPLIT, or IDLE for the len==0 case.
  - twd_rd_req_o is 0 in every other state.
- SPLIT:
  - out_req_o=1; out_add_o=cur_add.
  - out_len_o=min(row_len, rem); out_last_o=(rem<=row_len).
  - Outputs are registered/stable and must not change while out_gnt_i=0.
  - On out_gnt_i: cur_add += row_len + stride (modulo 2^ADDR_WIDTH, wrap silently), and rem -= out_len_o. The stride is the gap between the end of one row and the start of the next.
  - If out_last_o, go to IDLE; else the next row is presented in the following cycle.
- Latency, with the handshake at cycle N:
  - 1D: out_req_o at N+1.
  - 2D: twd_rd_req_o at N+1, first out_req_o at N+2.
  - Rows: 1 per cycle when out_gnt_i is held high.
  - Back-to-back: a new in handshake is possible in the cycle after the last-row grant.
- in_gnt_o=0 in FETCH/SPLIT; in_req_i is ignored there.
- Arithmetic: widths are zero-extended to ADDR_WIDTH/LEN_WIDTH. min() uses unsigned compare.

Test Plan:
- 1D, add 0x1000, len 64, twd 0, out_gnt_i=1 → one row at cycle N+1: add 0x1000, len 64, last 1. twd_rd_req_o never asserts. in_gnt_o is 0 at N+1 and 1 at N+2.
- 2D, add 0x1000, len 256, slot 2 = {stride 0xC0, count 64} → at N+1 twd_rd_req_o=1 for one cycle with twd_rd_add_o=2. Then rows 0x1000, 0x1100, 0x1200, 0x1300, each len 64, on consecutive cycles; last only on the 4th.
- Partial last row, add 0x0, len 150, {stride 64, count 64} → rows (0x0, 64), (0x80, 64), (0x100, 22, last).
- Backpressure: out_gnt_i low for 5 cycles during row 2 of the previous case → out_add_o/out_len_o/out_last_o stay constant at 0x80/64/0. The sequence resumes unchanged.
- Degenerate inputs:
  - count=0, len 100 → single row of len 100, last.
  - 2D with len 0 → one twd_rd_req_o pulse and no out_req_o.
  - 1D with len 0 → no outputs at all.
- Wrap and reset:
  - add 0xFFFFFF00, len 128, {stride 0x1C0, count 64} → second row add 0x00000100.
  - rst_i asserted during SPLIT → all outputs 0 the same cycle. IDLE with in_gnt_o=1 after release.
